// File: rtl/imem_pkg.sv
// Shared constants and state type for the instruction-memory boot controller.
package imem_pkg;

  localparam int          IMEM_ADDR_WIDTH = 10;
  localparam int          IMEM_DEPTH      = 1024;
  localparam logic [31:0] NOP_INSTR       = 32'h00000013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    FLUSH = 2'd3
  } boot_state_e;

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Bundle of the core fetch, boot loader and SRAM port signals around the controller.
// slave: the controller's view; master: the surrounding core, loader and SRAM.
interface imem_boot_ctrl_if
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH
) ();

  logic                  boot_start;
  logic [ADDR_WIDTH:0]   boot_len;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic [31:0]           core_pc;
  logic [31:0]           core_instr;
  logic                  core_stall;
  logic                  boot_busy;
  logic                  boot_done;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_write;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport slave (
    input  boot_start, boot_len, byte_valid, byte_data, core_pc, mem_rdata,
    output byte_ready, core_instr, core_stall, boot_busy, boot_done,
           mem_address, mem_write, mem_wdata
  );

  modport master (
    output boot_start, boot_len, byte_valid, byte_data, core_pc, mem_rdata,
    input  byte_ready, core_instr, core_stall, boot_busy, boot_done,
           mem_address, mem_write, mem_wdata
  );

endinterface

// File: rtl/imem_boot_ctrl_byte_packer.sv
// Packs a byte stream into little-endian words: first byte lands in bits [7:0].
module imem_boot_ctrl_byte_packer
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  word_valid_o,
  output logic [DATA_WIDTH-1:0] word_o
);

  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;

  // Next byte lane and count; the count wraps after the fourth byte.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    if (clear_i) begin
      byte_cnt_d = '0;
      asm_d      = '0;
    end else if (byte_valid_i) begin
      asm_d[{byte_cnt_q, 3'b000} +: 8] = byte_data_i;
      byte_cnt_d                       = byte_cnt_q + 2'd1;
    end
  end

  // Assembly registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
    end
  end

  assign word_valid_o = byte_valid_i && (byte_cnt_q == 2'd3);
  assign word_o       = asm_q;

endmodule

// File: rtl/imem_boot_ctrl.sv
// Instruction SRAM port arbiter: core fetch in RUN, sequential boot-load writes otherwise.
//
// state | meaning
// RUN   | port belongs to fetch; boot_start with nonzero length begins a load
// LOAD  | core stalled, collecting bytes of the current word
// WRITE | one-cycle SRAM write of the assembled word at word_cnt
// FLUSH | one-cycle completion pulse; fetch resumes the next cycle
module imem_boot_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = IMEM_DEPTH
) (
  input  logic             clock,
  input  logic             reset_n,
  imem_boot_ctrl_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  boot_state_e           state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH:0]   word_cnt_inc;
  logic                  pack_clr;
  logic                  byte_xfer;
  logic                  word_valid;
  logic [DATA_WIDTH-1:0] asm_word;
  logic                  unused_pc_bits;

  // Only the word-address bits of the PC select the SRAM row.
  assign unused_pc_bits = ^{bus.core_pc[31:ADDR_WIDTH+2], bus.core_pc[1:0]};

  assign byte_xfer    = (state_q == LOAD) && bus.byte_valid;
  assign word_cnt_inc = word_cnt_q + 1'b1;

  imem_boot_ctrl_byte_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear_i      (pack_clr),
    .byte_valid_i (byte_xfer),
    .byte_data_i  (bus.byte_data),
    .word_valid_o (word_valid),
    .word_o       (asm_word)
  );

  // State, saturated length and write pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      len_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Next-state logic plus the fetch/address/write muxes, all decoded from the current state.
  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    word_cnt_d      = word_cnt_q;
    pack_clr        = 1'b0;
    bus.byte_ready  = 1'b0;
    bus.core_stall  = 1'b1;
    bus.boot_busy   = 1'b1;
    bus.boot_done   = 1'b0;
    bus.core_instr  = NOP_INSTR;
    bus.mem_address = word_cnt_q[ADDR_WIDTH-1:0];
    bus.mem_write   = 1'b0;
    bus.mem_wdata   = '0;
    case (state_q)
      RUN: begin
        bus.core_stall  = 1'b0;
        bus.boot_busy   = 1'b0;
        bus.core_instr  = bus.mem_rdata;
        bus.mem_address = bus.core_pc[ADDR_WIDTH+1:2];
        // A zero-length request is dropped so no empty load ever pulses boot_done.
        if (bus.boot_start && (bus.boot_len != '0)) begin
          len_d      = (bus.boot_len > DEPTH_W) ? DEPTH_W : bus.boot_len;
          word_cnt_d = '0;
          pack_clr   = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        bus.byte_ready = 1'b1;
        if (word_valid) state_d = WRITE;
      end
      WRITE: begin
        bus.mem_write = 1'b1;
        bus.mem_wdata = asm_word;
        word_cnt_d    = word_cnt_inc;
        state_d       = (word_cnt_inc == len_q) ? FLUSH : LOAD;
      end
      FLUSH: begin
        bus.boot_done = 1'b1;
        state_d       = RUN;
      end
      default: state_d = RUN;
    endcase
  end

endmodule
